// File: rtl/adsr_envelope.sv
// ADSR envelope generator with an optional one-shot AD mode.
// The level moves only on strobe cycles; gate edges are detected against a registered copy of gate.
module adsr_envelope #(
    parameter int W           = 16,
    parameter bit RETRIG_ZERO = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         gate,
    input  logic         strobe,
    input  logic         mode,
    input  logic [W-1:0] attack_inc,
    input  logic [W-1:0] decay_inc,
    input  logic [W-1:0] sustain_level,
    input  logic [W-1:0] release_inc,
    output logic [W-1:0] level,
    output logic [2:0]   state,
    output logic         active,
    output logic         eoc
);
    localparam logic [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    env_state_t        cur_state;
    env_state_t        next_state;
    logic [W-1:0]      next_level;
    logic              gate_q;
    logic              mode_q;
    logic              next_mode;
    logic              next_eoc;
    logic              trigger;
    logic              release_ev;
    logic [W-1:0]      sustain_clamped;
    logic [W-1:0]      decay_target;
    logic [W:0]        attack_sum;
    logic signed [W:0] decay_diff;
    logic signed [W:0] release_diff;

    assign trigger    = gate & ~gate_q;
    assign release_ev = ~gate & gate_q;

    // Sums and differences are one bit wider than the level so overshoot is caught before it can wrap.
    assign sustain_clamped = (sustain_level > OUT_MAX) ? OUT_MAX : sustain_level;
    assign decay_target    = mode_q ? '0 : sustain_clamped;
    assign attack_sum      = {1'b0, level} + {1'b0, attack_inc};
    assign decay_diff      = $signed({1'b0, level}) - $signed({1'b0, decay_inc});
    assign release_diff    = $signed({1'b0, level}) - $signed({1'b0, release_inc});

    always_comb begin
        next_state = cur_state;
        next_level = level;
        next_mode  = mode_q;
        next_eoc   = 1'b0;
        if (trigger) begin
            next_state = ATTACK;
            next_mode  = mode;
            if (RETRIG_ZERO) begin
                next_level = '0;
            end
        end else if (release_ev && !mode_q &&
                     (cur_state == ATTACK || cur_state == DECAY || cur_state == SUSTAIN)) begin
            next_state = RELEASE;
        end else if (strobe) begin
            case (cur_state)
                ATTACK: begin
                    if (attack_sum >= {1'b0, OUT_MAX}) begin
                        next_level = OUT_MAX;
                        next_state = DECAY;
                    end else begin
                        next_level = attack_sum[W-1:0];
                    end
                end
                DECAY: begin
                    if (decay_diff <= $signed({1'b0, decay_target})) begin
                        next_level = decay_target;
                        next_state = mode_q ? IDLE : SUSTAIN;
                        next_eoc   = mode_q;
                    end else begin
                        next_level = decay_diff[W-1:0];
                    end
                end
                SUSTAIN: begin
                    next_level = sustain_clamped;
                end
                RELEASE: begin
                    if (release_diff <= $signed({(W+1){1'b0}})) begin
                        next_level = '0;
                        next_state = IDLE;
                        next_eoc   = 1'b1;
                    end else begin
                        next_level = release_diff[W-1:0];
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_level = '0;
                end
            endcase
        end
    end

    // active is registered from next_state so that every output changes on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= IDLE;
            level     <= '0;
            gate_q    <= 1'b0;
            mode_q    <= 1'b0;
            eoc       <= 1'b0;
            active    <= 1'b0;
        end else begin
            cur_state <= next_state;
            level     <= next_level;
            gate_q    <= gate;
            mode_q    <= next_mode;
            eoc       <= next_eoc;
            active    <= (next_state != IDLE);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed envelope scenarios followed by random gate/strobe/rate traffic,
// with both retrigger variants checked against an integer reference model on every cycle.
module tb_adsr_envelope;
    localparam int OUT_MAX   = 32767;
    localparam int S_IDLE    = 0;
    localparam int S_ATTACK  = 1;
    localparam int S_DECAY   = 2;
    localparam int S_SUSTAIN = 3;
    localparam int S_RELEASE = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        gate;
    logic        strobe;
    logic        mode;
    logic [15:0] attack_inc;
    logic [15:0] decay_inc;
    logic [15:0] sustain_level;
    logic [15:0] release_inc;
    logic [15:0] level0, level1;
    logic [2:0]  state0, state1;
    logic        active0, active1;
    logic        eoc0, eoc1;

    int checkCount = 0;
    int failCount  = 0;

    int m_state[2];
    int m_level[2];
    int m_mode[2];
    int m_eoc[2];
    int m_gate_q;

    always #5 clk = ~clk;

    adsr_envelope #(.W(16), .RETRIG_ZERO(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .gate(gate), .strobe(strobe), .mode(mode),
        .attack_inc(attack_inc), .decay_inc(decay_inc), .sustain_level(sustain_level),
        .release_inc(release_inc), .level(level0), .state(state0), .active(active0), .eoc(eoc0)
    );

    adsr_envelope #(.W(16), .RETRIG_ZERO(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .gate(gate), .strobe(strobe), .mode(mode),
        .attack_inc(attack_inc), .decay_inc(decay_inc), .sustain_level(sustain_level),
        .release_inc(release_inc), .level(level1), .state(state1), .active(active1), .eoc(eoc1)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = S_IDLE;
            m_level[k] = 0;
            m_mode[k]  = 0;
            m_eoc[k]   = 0;
        end
        m_gate_q = 0;
    endtask

    // One clock of the envelope rules in plain integer arithmetic; instance 1 zeroes on retrigger.
    task automatic modelStep();
        int trig, rel, ai, di, ri, sus, tgt, st, lv, md, e;
        trig = (gate == 1'b1 && m_gate_q == 0) ? 1 : 0;
        rel  = (gate == 1'b0 && m_gate_q == 1) ? 1 : 0;
        ai = attack_inc;
        di = decay_inc;
        ri = release_inc;
        sus = sustain_level;
        if (sus > OUT_MAX) sus = OUT_MAX;
        for (int k = 0; k < 2; k++) begin
            st = m_state[k];
            lv = m_level[k];
            md = m_mode[k];
            e  = 0;
            if (trig == 1) begin
                st = S_ATTACK;
                md = mode;
                if (k == 1) lv = 0;
            end else if (rel == 1 && md == 0 && st >= S_ATTACK && st <= S_SUSTAIN) begin
                st = S_RELEASE;
            end else if (strobe) begin
                case (st)
                    S_ATTACK: begin
                        if (lv + ai >= OUT_MAX) begin lv = OUT_MAX; st = S_DECAY; end
                        else lv = lv + ai;
                    end
                    S_DECAY: begin
                        tgt = (md == 1) ? 0 : sus;
                        if (lv - di <= tgt) begin
                            lv = tgt;
                            st = (md == 1) ? S_IDLE : S_SUSTAIN;
                            e  = md;
                        end else lv = lv - di;
                    end
                    S_SUSTAIN: lv = sus;
                    S_RELEASE: begin
                        if (lv - ri <= 0) begin lv = 0; st = S_IDLE; e = 1; end
                        else lv = lv - ri;
                    end
                    default: lv = 0;
                endcase
            end
            m_state[k] = st;
            m_level[k] = lv;
            m_mode[k]  = md;
            m_eoc[k]   = e;
        end
        m_gate_q = gate;
    endtask

    task automatic compareAll();
        int lv, st, ac, ec;
        for (int k = 0; k < 2; k++) begin
            lv = (k == 0) ? level0  : level1;
            st = (k == 0) ? state0  : state1;
            ac = (k == 0) ? active0 : active1;
            ec = (k == 0) ? eoc0    : eoc1;
            checkOutput($sformatf("level%0d", k), lv, m_level[k]);
            checkOutput($sformatf("state%0d", k), st, m_state[k]);
            checkOutput($sformatf("active%0d", k), ac, (m_state[k] != S_IDLE) ? 1 : 0);
            checkOutput($sformatf("eoc%0d", k), ec, m_eoc[k]);
            checkOutput($sformatf("bound%0d", k), (lv <= OUT_MAX) ? 1 : 0, 1);
        end
    endtask

    task automatic applyStimulus(input logic g, input logic s);
        gate   = g;
        strobe = s;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    // Pulls reset low mid-cycle, checks the immediate effect, then releases it after the next edge.
    task automatic asyncReset(input logic gateDuring);
        #2;
        gate    = gateDuring;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_async_level", level0, 0);
        checkOutput("rst_async_state", state0, S_IDLE);
        checkOutput("rst_async_eoc", eoc0, 0);
        checkOutput("rst_async_active", active0, 0);
        compareAll();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [15:0] randInc();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'($urandom_range(1, 255));
            default: return 16'($urandom_range(1, 8192));
        endcase
    endfunction

    initial begin
        int n;
        reset_n       = 1'b0;
        gate          = 1'b0;
        strobe        = 1'b0;
        mode          = 1'b0;
        attack_inc    = 16'h1000;
        decay_inc     = 16'h0800;
        sustain_level = 16'h4000;
        release_inc   = 16'h2000;
        modelReset();
        #12;
        checkOutput("reset_level", level0, 0);
        checkOutput("reset_state", state0, S_IDLE);
        checkOutput("reset_eoc", eoc0, 0);
        checkOutput("reset_active", active0, 0);
        reset_n = 1'b1;

        // Full ADSR cycle
        applyStimulus(1'b1, 1'b1);
        checkOutput("trig_state", state0, S_ATTACK);
        checkOutput("trig_level", level0, 0);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("attack_ramp", level0, 4096 * i);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("attack_top_level", level0, 32767);
        checkOutput("attack_top_state", state0, S_DECAY);
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("decay_sustain_level", level0, 16384);
        checkOutput("decay_sustain_state", state0, S_SUSTAIN);
        sustain_level = 16'h3000;
        applyStimulus(1'b1, 1'b1);
        checkOutput("sustain_follow", level0, 12288);
        sustain_level = 16'h4000;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("release_entry_state", state0, S_RELEASE);
        checkOutput("release_entry_level", level0, 16384);
        applyStimulus(1'b0, 1'b1);
        checkOutput("release_step", level0, 8192);
        applyStimulus(1'b0, 1'b1);
        checkOutput("release_end_level", level0, 0);
        checkOutput("release_end_state", state0, S_IDLE);
        checkOutput("release_end_eoc", eoc0, 1);
        checkOutput("release_end_active", active0, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("eoc_one_cycle", eoc0, 0);

        // Retrigger during release at 8192
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("retrig_pre_level", level0, 8192);
        applyStimulus(1'b1, 1'b1);
        checkOutput("retrig_state", state0, S_ATTACK);
        checkOutput("retrig_hold_level", level0, 8192);
        checkOutput("retrig_zero_level", level1, 0);
        checkOutput("retrig_no_eoc", eoc0, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("retrig_hold_next", level0, 12288);
        checkOutput("retrig_zero_next", level1, 4096);

        // One-shot AD with a one-cycle gate pulse
        asyncReset(1'b0);
        mode = 1'b1;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("oneshot_gate_fall_state", state0, S_ATTACK);
        checkOutput("oneshot_gate_fall_level", level0, 4096);
        for (int i = 2; i <= 8; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("oneshot_top_state", state0, S_DECAY);
        n = 0;
        while (n < 40) begin
            applyStimulus(1'b0, 1'b1);
            n++;
            if (state0 == 3'(S_IDLE)) break;
        end
        checkOutput("oneshot_decay_steps", n, 16);
        checkOutput("oneshot_eoc", eoc0, 1);
        checkOutput("oneshot_level", level0, 0);

        // Reset during attack, gate held high across reset release, strobe idle
        mode = 1'b0;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("pre_reset_level", level0, 8192);
        asyncReset(1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post_reset_state", state0, S_ATTACK);
        checkOutput("post_reset_level", level0, 0);
        checkOutput("post_reset_eoc", eoc0, 0);
        attack_inc = 16'h0000;
        applyStimulus(1'b1, 1'b1);
        checkOutput("zero_inc_stall", level0, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                attack_inc    = randInc();
                decay_inc     = randInc();
                release_inc   = randInc();
                sustain_level = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 799) == 0) asyncReset(1'($urandom_range(0, 1)));
            applyStimulus(gate ^ ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
